// File: rtl/sd_card_dat_pkg.sv
// sd_card_dat_pkg: FSM states and DAT line constants shared by the card-side DAT PHY.
package sd_card_dat_pkg;
    typedef enum logic [3:0] {
        IDLE, RX_WAIT_START, RX_DATA, RX_CRC, RX_END, BUSY, TX_START, TX_DATA, TX_CRC, TX_END
    } state_t;
    localparam logic [3:0] START_NIB = 4'h0;
    localparam logic [3:0] END_NIB = 4'hF;
    localparam logic [3:0] BUSY_NIB = 4'hE;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
endpackage

// File: rtl/sd_dat_crc16.sv
// sd_dat_crc16: four per-lane CRC16 registers, updated a nibble at a time and shifted out MSB-first.
module sd_dat_crc16
    import sd_card_dat_pkg::*;
(
    input  logic       sd_clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       shift,
    input  logic [3:0] din,
    output logic [3:0] crc_nib
);
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [15:0] crc;
        always_ff @(posedge sd_clk)
            crc <= (rst || clr) ? '0 :
                   en ? {crc[14:0], 1'b0} ^ ((crc[15] ^ din[i]) ? CRC16_POLY : 16'h0) :
                   shift ? {crc[14:0], 1'b0} : crc;
        assign crc_nib[i] = crc[15];
    end
endmodule

// File: rtl/sd_card_dat_phys.sv
// sd_card_dat_phys: card-side DAT[3:0] PHY receiving write blocks (then busy) and sending read blocks.
// Define SD_CARD_DAT_CRC_EN for per-lane CRC16 generation/checking; otherwise CRC slots carry zeros.
module sd_card_dat_phys
    import sd_card_dat_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BLK_SZ_W = 12,
    parameter int BUSY_CYCLES = 4
) (
    input  logic                sd_clk,
    input  logic                rst,
    input  logic [3:0]          DAT_din,
    output logic [3:0]          DAT_dout,
    output logic                DAT_dout_oe,
    input  logic [BLK_SZ_W-1:0] block_sz,
    input  logic                rx_start,
    input  logic                tx_start,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_data_valid,
    output logic                tx_data_rd,
    output logic [DATA_W-1:0]   rx_data,
    output logic                rx_data_wr,
    output logic                rx_err,
    output logic                tx_underrun,
    output logic                blk_done,
    output logic                card_phys_busy
);
    localparam int NPW = DATA_W / 4;
    localparam int WW = $clog2(NPW + 1);
    localparam int BW = $clog2(BUSY_CYCLES + 1);
`ifdef SD_CARD_DAT_CRC_EN
    localparam int CRC_CYC = 16;
`else
    localparam int CRC_CYC = 2;
`endif
    state_t state, state_d;
    logic [BLK_SZ_W:0] nib_left;
    logic [WW-1:0] wcnt;
    logic [3:0] ccnt;
    logic [BW-1:0] bcnt;
    logic [DATA_W-1:0] sh, rx_word, new_word;
    logic [3:0] tx_nib, crc_nib;
    logic err, rx_go, tx_go, nib_one, word_end, crc_last, busy_last, crc_mis;

    assign rx_go = rx_start && !tx_start;
    assign tx_go = tx_start && !rx_start && tx_data_valid;
    assign nib_one = nib_left == (BLK_SZ_W + 1)'(1);
    assign word_end = wcnt == WW'(NPW - 1);
    assign crc_last = ccnt == 4'(CRC_CYC - 1);
    assign busy_last = bcnt == BW'(BUSY_CYCLES - 1);
    assign rx_word = DATA_W'({sh, DAT_din});
    assign new_word = tx_data_valid ? tx_data : '0;
    assign tx_nib = (state == TX_DATA && word_end) ? new_word[DATA_W-1 -: 4] : sh[DATA_W-1 -: 4];
    assign tx_data_rd = (state == IDLE && tx_go) || (state == TX_DATA && word_end && nib_left != '0);
    assign card_phys_busy = state != IDLE;

`ifdef SD_CARD_DAT_CRC_EN
    sd_dat_crc16 u_crc (
        .sd_clk (sd_clk),
        .rst    (rst),
        .clr    (state == IDLE),
        .en     (state == TX_START || (state == TX_DATA && nib_left != '0) || state == RX_DATA),
        .shift  ((state == TX_DATA && nib_left == '0) || state == TX_CRC || state == RX_CRC),
        .din    (state == RX_DATA ? DAT_din : tx_nib),
        .crc_nib(crc_nib)
    );
    assign crc_mis = DAT_din != crc_nib;
`else
    assign crc_nib = '0;
    assign crc_mis = 1'b0;
`endif

    always_ff @(posedge sd_clk)
        state <= rst ? IDLE : state_d;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:          state_d = rx_go ? RX_WAIT_START : tx_go ? TX_START : IDLE;
            RX_WAIT_START: state_d = DAT_din == START_NIB ? RX_DATA : RX_WAIT_START;
            RX_DATA:       state_d = nib_one ? RX_CRC : RX_DATA;
            RX_CRC:        state_d = crc_last ? RX_END : RX_CRC;
            RX_END:        state_d = BUSY;
            BUSY:          state_d = busy_last ? IDLE : BUSY;
            TX_START:      state_d = TX_DATA;
            TX_DATA:       state_d = nib_left == '0 ? TX_CRC : TX_DATA;
            TX_CRC:        state_d = crc_last ? TX_END : TX_CRC;
            TX_END:        state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    always_ff @(posedge sd_clk) begin
        rx_data_wr <= 1'b0;
        blk_done <= 1'b0;
        rx_err <= 1'b0;
        if (rst) begin
            DAT_dout <= '0;
            DAT_dout_oe <= 1'b0;
            rx_data <= '0;
            tx_underrun <= 1'b0;
            nib_left <= '0;
            wcnt <= '0;
            ccnt <= '0;
            bcnt <= '0;
            sh <= '0;
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    nib_left <= {block_sz, 1'b0};
                    wcnt <= '0;
                    err <= 1'b0;
                    if (tx_go) begin
                        sh <= tx_data;
                        DAT_dout <= START_NIB;
                        DAT_dout_oe <= 1'b1;
                        tx_underrun <= 1'b0;
                    end
                end
                RX_DATA: begin
                    sh <= rx_word;
                    nib_left <= nib_left - 1'b1;
                    wcnt <= word_end ? '0 : wcnt + 1'b1;
                    ccnt <= '0;
                    if (word_end) begin
                        rx_data <= rx_word;
                        rx_data_wr <= 1'b1;
                    end
                end
                RX_CRC: begin
                    ccnt <= ccnt + 1'b1;
                    err <= err | crc_mis;
                end
                RX_END: begin
                    err <= err | (DAT_din != END_NIB);
                    DAT_dout <= BUSY_NIB;
                    DAT_dout_oe <= 1'b1;
                    bcnt <= '0;
                end
                BUSY: begin
                    bcnt <= bcnt + 1'b1;
                    if (busy_last) begin
                        DAT_dout <= '0;
                        DAT_dout_oe <= 1'b0;
                        blk_done <= 1'b1;
                        rx_err <= err;
                    end
                end
                TX_START: begin
                    DAT_dout <= tx_nib;
                    sh <= sh << 4;
                    nib_left <= nib_left - 1'b1;
                    wcnt <= '0;
                end
                TX_DATA: begin
                    ccnt <= '0;
                    if (nib_left == '0) begin
                        DAT_dout <= crc_nib;
                    end else begin
                        // A missing word is replaced by zeros so the block keeps its timing.
                        DAT_dout <= tx_nib;
                        sh <= (word_end ? new_word : sh) << 4;
                        wcnt <= word_end ? '0 : wcnt + 1'b1;
                        nib_left <= nib_left - 1'b1;
                        if (word_end && !tx_data_valid) tx_underrun <= 1'b1;
                    end
                end
                TX_CRC: begin
                    ccnt <= ccnt + 1'b1;
                    DAT_dout <= crc_last ? END_NIB : crc_nib;
                end
                TX_END: begin
                    DAT_dout <= '0;
                    DAT_dout_oe <= 1'b0;
                    blk_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_card_dat_phys.sv
// tb_sd_card_dat_phys: table-driven TX/RX block checks with nibble and word scoreboards.
module tb_sd_card_dat_phys;
`ifdef SD_CARD_DAT_CRC_EN
    localparam int CRC_CYC = 16;
    localparam bit CRC_EN = 1'b1;
`else
    localparam int CRC_CYC = 2;
    localparam bit CRC_EN = 1'b0;
`endif
    logic sd_clk = 1'b0, rst = 1'b1;
    logic [3:0] DAT_din = 4'hF, DAT_dout;
    logic DAT_dout_oe, rx_start = 1'b0, tx_start = 1'b0, tx_data_valid = 1'b0;
    logic [11:0] block_sz = 12'd4;
    logic [31:0] tx_data = '0, rx_data;
    logic tx_data_rd, rx_data_wr, rx_err, tx_underrun, blk_done, card_phys_busy;

    typedef struct {
        bit          is_tx;
        logic [11:0] bsz;
        logic [31:0] w0, w1;
        logic [3:0]  end_nib;
        bit          valid2;
        bit          crc_flip;
        bit          exp_under;
    } vec_t;

    vec_t vecs [7];
    logic [3:0] exp_q [$];
    logic [31:0] rx_q [$];
    logic [15:0] mcrc [4];
    int checks = 0, errors = 0;

    sd_card_dat_phys dut (
        .sd_clk(sd_clk), .rst(rst), .DAT_din(DAT_din), .DAT_dout(DAT_dout), .DAT_dout_oe(DAT_dout_oe),
        .block_sz(block_sz), .rx_start(rx_start), .tx_start(tx_start), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid), .tx_data_rd(tx_data_rd), .rx_data(rx_data), .rx_data_wr(rx_data_wr),
        .rx_err(rx_err), .tx_underrun(tx_underrun), .blk_done(blk_done), .card_phys_busy(card_phys_busy)
    );

    always #5 sd_clk = ~sd_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sd_clk);
        #1;
        if (rx_data_wr) begin
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected_push: got %0h expected no push", rx_data);
            end else chk("rx_data", rx_data, rx_q.pop_front());
        end
    endtask

    task automatic crc_clear();
        for (int l = 0; l < 4; l++) mcrc[l] = '0;
    endtask

    task automatic crc_upd(input logic [3:0] d);
        for (int l = 0; l < 4; l++)
            mcrc[l] = {mcrc[l][14:0], 1'b0} ^ ((mcrc[l][15] ^ d[l]) ? 16'h1021 : 16'h0);
    endtask

    function automatic logic [3:0] model_crc_nib(input int i);
        return {mcrc[3][15-i], mcrc[2][15-i], mcrc[1][15-i], mcrc[0][15-i]};
    endfunction

    task automatic run_tx(input vec_t v);
        logic [31:0] w;
        logic [3:0] e;
        int n, k, nn;
        nn = 2 * int'(v.bsz);
        exp_q.delete();
        crc_clear();
        exp_q.push_back(4'h0);
        for (int j = 0; j < int'(v.bsz) / 4; j++) begin
            w = j == 0 ? v.w0 : (v.valid2 ? v.w1 : 32'h0);
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back(w[31-4*i -: 4]);
                crc_upd(w[31-4*i -: 4]);
            end
        end
        for (int i = 0; i < CRC_CYC; i++) exp_q.push_back(CRC_EN ? model_crc_nib(i) : 4'h0);
        exp_q.push_back(4'hF);
        n = exp_q.size();
        block_sz = v.bsz;
        tx_data = v.w0;
        tx_data_valid = 1'b1;
        tx_start = 1'b1;
        #1;
        chk("tx_rd_accept", tx_data_rd, 1);
        step();
        tx_start = 1'b0;
        tx_data = v.w1;
        tx_data_valid = v.valid2;
        chk("tx_underrun_cleared", tx_underrun, 0);
        k = 0;
        for (int c = 0; c < n + 4 && DAT_dout_oe && exp_q.size() != 0; c++) begin
            e = exp_q.pop_front();
            chk("tx_dat", DAT_dout, e);
            chk("tx_rd", tx_data_rd, k >= 8 && k % 8 == 0 && k < nn);
            k++;
            step();
        end
        chk("tx_oe_cycles", k, n);
        chk("tx_oe_end", DAT_dout_oe, 0);
        chk("tx_blk_done", blk_done, 1);
        chk("tx_underrun", tx_underrun, v.exp_under);
        step();
        chk("tx_blk_done_pulse", blk_done, 0);
        chk("tx_idle", card_phys_busy, 0);
    endtask

    task automatic run_rx(input vec_t v);
        logic [31:0] w;
        crc_clear();
        block_sz = v.bsz;
        rx_start = 1'b1;
        step();
        rx_start = 1'b0;
        chk("rx_armed", card_phys_busy, 1);
        chk("rx_oe_off", DAT_dout_oe, 0);
        DAT_din = 4'hF;
        repeat (3) step();
        DAT_din = 4'h0;
        step();
        for (int j = 0; j < int'(v.bsz) / 4; j++) begin
            w = j == 0 ? v.w0 : v.w1;
            for (int i = 0; i < 8; i++) begin
                DAT_din = w[31-4*i -: 4];
                crc_upd(DAT_din);
                if (i == 7) rx_q.push_back(w);
                step();
            end
        end
        for (int i = 0; i < CRC_CYC; i++) begin
            DAT_din = (CRC_EN ? model_crc_nib(i) : 4'h0) ^ ((i == 0 && v.crc_flip) ? 4'h4 : 4'h0);
            step();
        end
        DAT_din = v.end_nib;
        step();
        DAT_din = 4'hF;
        for (int b = 0; b < 4; b++) begin
            chk("rx_busy_oe", DAT_dout_oe, 1);
            chk("rx_busy_dat", DAT_dout, 4'hE);
            chk("rx_busy_no_done", blk_done, 0);
            step();
        end
        chk("rx_oe_release", DAT_dout_oe, 0);
        chk("rx_blk_done", blk_done, 1);
        chk("rx_err", rx_err, v.end_nib != 4'hF || (CRC_EN && v.crc_flip));
        chk("rx_words_left", rx_q.size(), 0);
        rx_q.delete();
        step();
        chk("rx_blk_done_pulse", blk_done, 0);
        chk("rx_err_pulse", rx_err, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 12'd4, 32'hA5C30F12, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 12'd8, 32'h12345678, 32'h9ABCDEF0, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 12'd4, 32'hDEADBEEF, 32'h0, 4'h7, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 12'd8, 32'h01234567, 32'h89ABCDEF, 4'hF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 12'd8, 32'h0F1E2D3C, 32'h4B5A6978, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 12'd4, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 12'd4, 32'h0, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0};

        repeat (2) step();
        rst = 1'b0;
        chk("rst_dout", DAT_dout, 0);
        chk("rst_oe", DAT_dout_oe, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_wr", rx_data_wr, 0);
        chk("rst_rx_err", rx_err, 0);
        chk("rst_underrun", tx_underrun, 0);
        chk("rst_blk_done", blk_done, 0);
        chk("rst_busy", card_phys_busy, 0);

        for (int t = 0; t < 7; t++) begin
            if (vecs[t].is_tx) run_tx(vecs[t]);
            else run_rx(vecs[t]);
        end

        rx_start = 1'b1;
        tx_start = 1'b1;
        tx_data_valid = 1'b1;
        #1;
        chk("both_no_rd", tx_data_rd, 0);
        step();
        rx_start = 1'b0;
        tx_start = 1'b0;
        chk("both_oe", DAT_dout_oe, 0);
        chk("both_idle", card_phys_busy, 0);

        tx_start = 1'b1;
        tx_data_valid = 1'b0;
        step();
        tx_start = 1'b0;
        tx_data_valid = 1'b1;
        chk("novalid_idle", card_phys_busy, 0);
        step();
        chk("novalid_not_latched", card_phys_busy, 0);
        chk("novalid_oe", DAT_dout_oe, 0);

        block_sz = 12'd8;
        tx_data = 32'hCAFEF00D;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (4) step();
        chk("midtx_oe", DAT_dout_oe, 1);
        rst = 1'b1;
        step();
        chk("midrst_oe", DAT_dout_oe, 0);
        chk("midrst_dout", DAT_dout, 0);
        chk("midrst_busy", card_phys_busy, 0);
        chk("midrst_done", blk_done, 0);
        rst = 1'b0;
        step();
        chk("post_rst_idle", card_phys_busy, 0);
        chk("post_rst_oe", DAT_dout_oe, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_card_dat_phys.md
# sd_card_dat_phys

Card-side DAT[3:0] physical layer for the SD host controller's DAT path: the counterpart of the host DAT engine, used as the card end of the link in system simulation and FPGA loopback. It receives host write blocks (start nibble, data, CRC, end nibble), then signals busy on DAT0. It transmits read blocks toward the host with the same framing. Word-wide data moves through a simple pop/push interface to card-side storage.

## Interface
- DATA_W, 32, word width; must be a multiple of 4
- BLK_SZ_W, 12, width of block_sz
- BUSY_CYCLES, 4, cycles DAT0 is held low after a write block (≥1)
- sd_clk  in  1  card clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- DAT_din  in  4  DAT lines as driven by host
- DAT_dout  out  4  DAT lines driven by card
- DAT_dout_oe  out  1  card output enable
- block_sz  in  BLK_SZ_W  block size in bytes, multiple of DATA_W/8, nonzero; sampled at start
- rx_start  in  1  arm reception of one write block
- tx_start  in  1  start transmission of one read block
- tx_data  in  DATA_W  next word to send
- tx_data_valid  in  1  tx_data available
- tx_data_rd  out  1  pop pulse; word captured on same edge
- rx_data  out  DATA_W  received word
- rx_data_wr  out  1  one-cycle push strobe for rx_data
- rx_err  out  1  one-cycle pulse with blk_done on CRC or end-nibble mismatch
- tx_underrun  out  1  sticky; cleared by next tx_start
- blk_done  out  1  one-cycle pulse at end of block
- card_phys_busy  out  1  state != IDLE

## Operation
- States: IDLE, RX_WAIT_START, RX_DATA, RX_CRC, RX_END, BUSY, TX_START, TX_DATA, TX_CRC, TX_END.
- IDLE: DAT_dout_oe=0. Sampled rx_start&&!tx_start -> RX_WAIT_START. Sampled tx_start&&!rx_start&&tx_data_valid -> TX_START. Both asserted -> ignored, stay IDLE. tx_start without valid stays IDLE; the request is not latched.
- Nibble count per block = 2*block_sz, latched at start. Nibbles go MSB-first within each word.
- RX_WAIT_START: wait for DAT_din==4'h0, with no timeout. Then RX_DATA.
- RX_DATA: shift one nibble per cycle. After the DATA_W/4-th nibble of each word: rx_data_wr=1 and rx_data=word, registered on the next cycle. After the last nibble -> RX_CRC.
- RX_CRC: CRC_CYC cycles, then RX_END. RX_END samples DAT_din once; a value other than 4'hF flags the error. -> BUSY.
- BUSY: DAT_dout=4'hE, oe=1 for BUSY_CYCLES cycles. Then oe=0, blk_done=1, rx_err as computed, -> IDLE.
- TX_START: DAT_dout=4'h0, oe=1. The first word was captured with tx_data_rd at the accepting edge.
- TX_DATA: one nibble per cycle. tx_data_rd is asserted combinationally in the cycle the last nibble of a word is output, provided words remain. If tx_data_valid=0 there, set tx_underrun and send 4'h0 for that word. Do not stall.
- TX_CRC: CRC_CYC cycles. TX_END: DAT_dout=4'hF. Next cycle oe=0, blk_done=1, -> IDLE.
- Counters saturate-free: the nibble counter is BLK_SZ_W+1 bits, and the busy counter is clog2(BUSY_CYCLES+1) bits.

## Timing
- Reset values: DAT_dout=0, DAT_dout_oe=0, rx_data=0, and all pulses plus tx_underrun=0. The FSM goes to IDLE.
- Reset mid-operation: outputs take reset values on the reset edge. Nothing partial is pushed or flagged.
- TX latency: tx_start accepted at edge n gives start nibble at n+1, first data nibble at n+2, and last data nibble at n+1+2*block_sz.
- RX: the start nibble sampled at edge m makes the first data nibble due at edge m+1.
- DAT_dout and DAT_dout_oe are registered. tx_data_rd is combinational from state and counters only.

## Configuration
- SD_CARD_DAT_CRC_EN defined: CRC_CYC=16, with one CRC16 (x^16+x^12+x^5+1, init 0) per lane over that lane's data bits. TX sends the lane CRCs MSB-first. RX compares them, and any mismatch sets rx_err.
- Undefined: CRC_CYC=2. TX sends 4'h0 on both cycles. RX ignores the CRC nibbles, so only the end nibble can raise rx_err.

## Structure
- Package sd_card_dat_pkg: state enum, START_NIB=4'h0, END_NIB=4'hF, BUSY_NIB=4'hE, CRC16_POLY=16'h1021.
- Sub-module sd_dat_crc16: 4 lane CRC16 registers with clear, nibble-enable, and a serial shift-out. It is instantiated only under SD_CARD_DAT_CRC_EN.

## Test plan
- TX, block_sz=4, tx_data=32'hA5C30F12, CRC disabled -> DAT_dout 0,A,5,C,3,0,F,1,2,0,0,F; oe high for 12 cycles; blk_done 1 cycle after F.
- RX, block_sz=8: host drives 0, then nibbles of 32'h12345678 and 32'h9ABCDEF0, CRC, then F -> two rx_data_wr pulses with those words, then 4'hE for BUSY_CYCLES=4, then blk_done with rx_err=0.
- RX with end nibble 4'h7 -> busy still driven; rx_err=1 with blk_done.
- TX, block_sz=8, tx_data_valid low at the second word boundary -> second word sent as eight 4'h0, tx_underrun=1, and a new tx_start clears it.
- rx_start and tx_start asserted together in IDLE -> oe stays 0 and the FSM stays IDLE. rst pulsed mid-TX_DATA -> oe=0 on the next edge.
- CRC enabled: RX of one block of all-zero data with a correct CRC gives rx_err=0. Flipping one bit of lane 2's CRC gives rx_err=1.
